// File: rtl/aes32_pkg.sv
// Shared types and GF(2^8) helpers for the aes32 execution pipe.
// S-boxes are computed from the field inverse plus the AES affine maps.
package aes32_pkg;

    typedef enum logic [1:0] {
        AES32_ESI  = 2'd0,
        AES32_ESMI = 2'd1,
        AES32_DSI  = 2'd2,
        AES32_DSMI = 2'd3
    } aes32_op_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] y;
        y = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [31:0] rol32_bytes(input logic [31:0] u, input logic [1:0] bs);
        case (bs)
            2'd0:    return u;
            2'd1:    return {u[23:0], u[31:24]};
            2'd2:    return {u[15:0], u[31:16]};
            default: return {u[7:0], u[31:8]};
        endcase
    endfunction

endpackage

// File: rtl/aes32_sbox_lane.sv
// Byte substitution and column-mix lane; the stage-1 register sits between s and s_q.
// Inverse S-box and DSMI mixing exist only when AES32_DEC_EN is defined.
module aes32_sbox_lane
    import aes32_pkg::*;
(
    input  logic [7:0]  x,
    input  aes32_op_e   op,
    output logic [7:0]  s,
    input  logic [7:0]  s_q,
    input  aes32_op_e   op_q,
    output logic [31:0] u
);

    always_comb begin
`ifdef AES32_DEC_EN
        s = op[1] ? inv_sbox(x) : sbox(x);
`else
        s = (op == AES32_ESI) ? sbox(x) : sbox(x);
`endif
    end

    always_comb begin
        u = {24'h0, s_q};
        case (op_q)
            AES32_ESMI: u = {gf_mul(8'h03, s_q), s_q, s_q, xtime(s_q)};
`ifdef AES32_DEC_EN
            AES32_DSMI: u = {gf_mul(8'h0b, s_q), gf_mul(8'h0d, s_q),
                             gf_mul(8'h09, s_q), gf_mul(8'h0e, s_q)};
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/aes32_exec_pipe.sv
// Pipelined aes32{e,d}s{m}i execution unit with valid/ready handshake and tag passthrough.
// Decrypt ops are built only with AES32_DEC_EN; otherwise they retire with out_illegal=1, result=rs1.
module aes32_exec_pipe
    import aes32_pkg::*;
#(
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [1:0]       in_bs,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic             busy
);

    logic                 advance;
    logic [PIPE_STAGES:1] vld_q;
    logic [PIPE_STAGES:0] vld_pipe;

    // Whole pipe moves in lockstep; bubbles are kept, never squeezed out.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign vld_pipe  = {vld_q, in_valid && advance};
    assign out_valid = vld_q[PIPE_STAGES];
    assign busy      = |vld_q;

    always_ff @(posedge clk) begin
        if (rst)          vld_q <= '0;
        else if (advance) vld_q <= vld_pipe[PIPE_STAGES-1:0];
    end

    aes32_op_e  op_in;
    logic [7:0] x_in;
    logic [7:0] s_in;
    logic       ill_in;

    assign op_in = aes32_op_e'(in_op);
    assign x_in  = in_rs2[{in_bs, 3'b000} +: 8];
`ifdef AES32_DEC_EN
    assign ill_in = 1'b0;
`else
    assign ill_in = in_op[1];
`endif

    logic [7:0]       a_s;
    aes32_op_e        a_op;
    logic [1:0]       a_bs;
    logic [31:0]      a_rs1;
    logic [TAG_W-1:0] a_tag;
    logic             a_ill;
    logic [31:0]      a_u;

    aes32_sbox_lane u_lane (
        .x    (x_in),
        .op   (op_in),
        .s    (s_in),
        .s_q  (a_s),
        .op_q (a_op),
        .u    (a_u)
    );

    if (PIPE_STAGES >= 2) begin : g_stage_a
        always_ff @(posedge clk) begin
            if (rst) begin
                a_s   <= '0;
                a_op  <= AES32_ESI;
                a_bs  <= '0;
                a_rs1 <= '0;
                a_tag <= '0;
                a_ill <= 1'b0;
            end else if (advance) begin
                a_s   <= s_in;
                a_op  <= op_in;
                a_bs  <= in_bs;
                a_rs1 <= in_rs1;
                a_tag <= in_tag;
                a_ill <= ill_in;
            end
        end
    end else begin : g_pass_a
        assign a_s   = s_in;
        assign a_op  = op_in;
        assign a_bs  = in_bs;
        assign a_rs1 = in_rs1;
        assign a_tag = in_tag;
        assign a_ill = ill_in;
    end

    logic [31:0]      b_u;
    logic [1:0]       b_bs;
    logic [31:0]      b_rs1;
    logic [TAG_W-1:0] b_tag;
    logic             b_ill;

    // Deepest build cuts again after the GF multiplies.
    if (PIPE_STAGES >= 3) begin : g_stage_b
        always_ff @(posedge clk) begin
            if (rst) begin
                b_u   <= '0;
                b_bs  <= '0;
                b_rs1 <= '0;
                b_tag <= '0;
                b_ill <= 1'b0;
            end else if (advance) begin
                b_u   <= a_u;
                b_bs  <= a_bs;
                b_rs1 <= a_rs1;
                b_tag <= a_tag;
                b_ill <= a_ill;
            end
        end
    end else begin : g_pass_b
        assign b_u   = a_u;
        assign b_bs  = a_bs;
        assign b_rs1 = a_rs1;
        assign b_tag = a_tag;
        assign b_ill = a_ill;
    end

    logic [31:0] res;
    assign res = b_ill ? b_rs1 : (b_rs1 ^ rol32_bytes(b_u, b_bs));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_result  <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (advance) begin
            out_result  <= res;
            out_tag     <= b_tag;
            out_illegal <= b_ill;
        end
    end

endmodule

// File: tb/tb_aes32_exec_pipe.sv
// Directed self-checking bench for aes32_exec_pipe (PIPE_STAGES=2); decrypt
// expectations follow AES32_DEC_EN.
module tb_aes32_exec_pipe;

    localparam int P = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = '0;
    logic [1:0]  in_bs = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;
    logic        busy;

    int checks = 0;
    int errors = 0;

    aes32_exec_pipe #(.PIPE_STAGES(P), .TAG_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_bs       (in_bs),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op into an idle pipe and check latency, result, tag and illegal flag.
    task automatic run_op(input string name, input logic [1:0] op, input logic [1:0] bs,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] tag,
                          input logic [31:0] exp_res, input logic exp_ill);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_bs = bs; in_rs1 = rs1; in_rs2 = rs2; in_tag = tag;
        chk({name, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'(P));
        chk({name, "_res"}, out_result, exp_res);
        chk({name, "_tag"}, 32'(out_tag), 32'(tag));
        chk({name, "_ill"}, 32'(out_illegal), 32'(exp_ill));
    endtask

    initial begin
        int          acc;
        int          got;
        logic        rdy;
        logic        stale;
        logic [4:0]  tags [4];
        logic [31:0] ress [4];

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Encrypt ops
        run_op("esi_bs1", 2'd0, 2'd1, 32'h11223344, 32'hA1B2C3D4, 5'd3, 32'h11221D44, 1'b0);
        run_op("esi_bs0", 2'd0, 2'd0, 32'hFFFFFFFF, 32'hA1B2C3D4, 5'd7, 32'hFFFFFFB7, 1'b0);
        run_op("esmi_bs0", 2'd1, 2'd0, 32'h0, 32'h0, 5'd5, 32'hA56363C6, 1'b0);
        run_op("esmi_bs1", 2'd1, 2'd1, 32'h0, 32'h0, 5'd6, 32'h6363C6A5, 1'b0);

        // Decrypt ops
`ifdef AES32_DEC_EN
        run_op("dsi_bs2", 2'd2, 2'd2, 32'h11223344, 32'h007C0000, 5'd8, 32'h11233344, 1'b0);
        run_op("dsmi_bs0", 2'd3, 2'd0, 32'h0, 32'h0000007C, 5'd9, 32'h0B0D090E, 1'b0);
`else
        run_op("dsi_ill", 2'd2, 2'd0, 32'hCAFEBABE, 32'h12345678, 5'd8, 32'hCAFEBABE, 1'b1);
        run_op("dsmi_ill", 2'd3, 2'd1, 32'hCAFEBABE, 32'h0000007C, 5'd9, 32'hCAFEBABE, 1'b1);
`endif

        // Backpressure: ESI bs=0 rs2=0 gives rs1 ^ 0x63; rs1 = tag
        @(negedge clk);
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            in_valid = 1'b1; in_op = 2'd0; in_bs = 2'd0; in_rs2 = 32'h0;
            in_tag = 5'(acc + 1); in_rs1 = 32'(acc + 1);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) acc++;
        end
        @(negedge clk);
        chk("bp_accepts", 32'(acc), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        chk("bp_hold_tag", 32'(out_tag), 32'd1);
        chk("bp_hold_res", out_result, 32'h00000062);

        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0) begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end else if (acc < 4) begin
                in_valid = 1'b1; in_tag = 5'(acc + 1); in_rs1 = 32'(acc + 1);
            end else begin
                in_valid = 1'b0;
            end
            rdy = in_ready;
            if (out_valid) begin
                tags[got] = out_tag;
                ress[got] = out_result;
                got++;
            end
            @(posedge clk);
            if (rdy && in_valid) acc++;
        end
        in_valid = 1'b0;
        chk("bp_total_out", 32'(got), 32'd4);
        for (int i = 0; i < got; i++) begin
            chk($sformatf("bp_order_tag%0d", i), 32'(tags[i]), 32'(i + 1));
            chk($sformatf("bp_order_res%0d", i), ress[i], 32'(i + 1) ^ 32'h63);
        end
        @(negedge clk);
        chk("bp_drained_busy", 32'(busy), 32'd0);
        chk("bp_drained_valid", 32'(out_valid), 32'd0);

        // Reset mid-flight
        in_valid = 1'b1; in_op = 2'd0; in_bs = 2'd0; in_rs1 = 32'h0; in_rs2 = 32'h0; in_tag = 5'd9;
        @(posedge clk);
        @(negedge clk);
        in_tag = 5'd10;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        in_tag = 5'd11;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        stale = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid || busy) stale = 1'b1;
        end
        chk("mrst_no_stale", 32'(stale), 32'd0);

        run_op("post_rst_esi", 2'd0, 2'd1, 32'h11223344, 32'hA1B2C3D4, 5'd12, 32'h11221D44, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes32_exec_pipe.md
Name: aes32_exec_pipe

Overview:
Parametrised, pipelined successor to the single-cycle combinational aes32esi unit. Executes all four RISC-V Zkne/Zknd 32-bit AES ops (aes32esi, aes32esmi, aes32dsi, aes32dsmi) behind a valid/ready handshake, with configurable latency and a tag carried per op. Sits between the issue stage and writeback of the crypto execution cluster.

Parameters:
PIPE_STAGES, 2, latency in cycles from accept to out_valid; legal range 1..3.
TAG_W, 5, width of the opaque tag passed through with each op (destination register index).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  op presented
in_ready  output  1  unit can accept this cycle
in_op  input  2  0=ESI, 1=ESMI, 2=DSI, 3=DSMI
in_bs  input  2  byte select
in_rs1  input  32  accumulator operand
in_rs2  input  32  source operand
in_tag  input  TAG_W  op tag
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_result  output  32  result word
out_tag  output  TAG_W  tag of result
out_illegal  output  1  op not supported in this build
busy  output  1  one or more ops in flight

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset: all stage valid bits cleared; out_valid=0, out_result=0, out_tag=0, out_illegal=0, busy=0. in_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation: every in-flight op is dropped with no output. An op presented in the same cycle as rst is not accepted.
- Arithmetic: x = byte bs of rs2, i.e. rs2[8*bs+7:8*bs]. ESI/ESMI use s = SBOX(x); DSI/DSMI use s = INV_SBOX(x).
  - ESI/DSI: u = {24'h0, s}.
  - ESMI: u = {3*s, s, s, 2*s} (bits 31:24 first).
  - DSMI: u = {0B*s, 0D*s, 09*s, 0E*s}.
  - All products are in GF(2^8) mod 0x11B.
  - result = rs1 ^ rol32(u, 8*bs).
- Pipeline: PIPE_STAGES register stages; each stage carries a valid bit, the data, the tag and the illegal flag.
  - Split for PIPE_STAGES>=2: stage 1 registers s, op, bs and rs1; the last stage registers the result.
  - PIPE_STAGES=3 adds a register after the GF multiply.
- Handshake: advance = !out_valid | out_ready. The whole pipeline shifts when advance=1 and holds all stages when advance=0. in_ready = advance.
  - An op is accepted iff in_valid & in_ready.
  - A result transfers iff out_valid & out_ready.
- Ordering and bubbles: bubbles propagate as invalid stages and are not compressed. Results leave strictly in acceptance order.
- Stability: out_result, out_tag and out_illegal are stable while out_valid=1 and out_ready=0.
- Throughput: 1 op/cycle with out_ready held high. Latency is exactly PIPE_STAGES cycles: accept at edge N, out_valid high after edge N+PIPE_STAGES.
- busy: OR of all stage valid bits.

Optional Feature:
- Macro: AES32_DEC_EN.
- Defined: DSI and DSMI are implemented as above, and the INV_SBOX logic is instantiated.
- Undefined: no inverse S-box logic is instantiated.
  - An op with in_op[1]=1 still flows through the pipeline at normal latency.
  - It completes with out_illegal=1 and out_result=in_rs1 unchanged.

Decomposition:
- Package aes32_pkg holds:
  - op enum constants AES32_ESI, AES32_ESMI, AES32_DSI, AES32_DSMI;
  - SBOX and INV_SBOX constant tables or functions;
  - xtime and gf_mul functions.
- Sub-module aes32_sbox_lane: combinational; takes x and op, produces the 32-bit u word before rotation. It is shared by all modes and is the boundary for the stage-1 register.

Test Plan:
- ESI: rs1=0x11223344, rs2=0xA1B2C3D4, bs=1 -> result 0x11221D44; ESI, rs1=0xFFFFFFFF, bs=0 -> 0xFFFFFFB7.
- ESMI: rs1=0, rs2=0, bs=0 -> 0xA56363C6; same op with bs=1 -> 0x6363C6A5.
- DSI (AES32_DEC_EN defined): rs1=0x11223344, rs2=0x007C0000, bs=2 -> 0x11233344; DSMI, rs1=0, rs2=0x0000007C, bs=0 -> 0x0B0D090E.
- Backpressure: PIPE_STAGES=2, issue tags 1..4 back-to-back with out_ready=0.
  - Expected: in_ready drops after 2 accepts plus the held output.
  - Expected: release out_ready, then all 4 results emerge in order 1..4 with correct values, none lost or duplicated.
- Reset mid-flight: accept 2 ops, assert rst for 1 cycle -> out_valid=0 and busy=0 the next cycle, no stale result afterwards.
- AES32_DEC_EN undefined: DSI with rs1=0xCAFEBABE -> out_illegal=1, out_result=0xCAFEBABE, latency unchanged.
